// File: rtl/sprite_blit_if.sv
// Handshake, ROM and VGA-plot signals of the sprite blit engine.
// The engine uses the slave modport. The game FSM, the ROMs and the
// adapter together use the master modport.
interface sprite_blit_if;
  logic        start_draw;
  logic        start_clear;
  logic [7:0]  pos_x;
  logic [6:0]  pos_y;
  logic [10:0] sprite_addr;
  logic [2:0]  sprite_q;
  logic [14:0] screen_addr;
  logic [2:0]  screen_q;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic        busy;
  logic        done;

  modport slave (
    input  start_draw, start_clear, pos_x, pos_y, sprite_q, screen_q,
    output sprite_addr, screen_addr, vga_x, vga_y, vga_colour, plot, busy, done
  );

  modport master (
    output start_draw, start_clear, pos_x, pos_y, sprite_q, screen_q,
    input  sprite_addr, screen_addr, vga_x, vga_y, vga_colour, plot, busy, done
  );
endinterface

// File: rtl/sprite_blit_engine.sv
// Sprite blit engine. It sweeps either the whole background image or one
// sprite through a synchronous ROM. Each returned colour becomes a VGA
// plot one cycle later. Sprite pixels that are transparent or fall off the
// screen are clipped.
module sprite_blit_engine #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter int         SPRITE_W    = 40,
  parameter int         SPRITE_H    = 40,
  parameter logic [2:0] TRANSPARENT = 3'b000
) (
  input  logic         clk,
  input  logic         reset,
  sprite_blit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FLUSH} state_t;

  state_t      state, state_next;
  logic [7:0]  col;
  logic [6:0]  row;
  logic [14:0] row_base;
  logic [7:0]  lat_x;
  logic [6:0]  lat_y;
  logic [8:0]  x_d;
  logic [7:0]  y_d;
  logic        valid_d, clear_d, onscreen_d;

  logic        is_clear, issuing, last_col, last_row;
  logic [8:0]  x_sum;
  logic [7:0]  y_sum;
  logic [2:0]  q_sel;

  assign is_clear = (state == CLEAR);
  assign issuing  = (state == CLEAR) || (state == DRAW);
  assign last_col = is_clear ? (col == 8'(SCREEN_W - 1)) : (col == 8'(SPRITE_W - 1));
  assign last_row = is_clear ? (row == 7'(SCREEN_H - 1)) : (row == 7'(SPRITE_H - 1));

  // Sums are one bit wider than the VGA coordinates, so off-screen pixels clip instead of wrapping.
  assign x_sum = 9'(lat_x) + 9'(col);
  assign y_sum = 8'(lat_y) + 8'(row);

  // State register. Reset is synchronous and wins over every transition.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. A clear request beats a draw request; a dropped draw is not remembered.
  always_comb begin
    // NOTE: default first, so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.start_clear)     state_next = CLEAR;
        else if (bus.start_draw) state_next = DRAW;
      end
      CLEAR, DRAW: if (last_col && last_row) state_next = FLUSH;
      FLUSH:       state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // Latch the sprite position when a draw request is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_x <= '0;
      lat_y <= '0;
    end else if (state == IDLE && bus.start_draw && !bus.start_clear) begin
      lat_x <= bus.pos_x;
      lat_y <= bus.pos_y;
    end
  end

  // Column and row counters. The row base is kept as a running sum, so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (reset || !issuing) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (last_col) begin
      col      <= '0;
      row      <= row + 7'd1;
      row_base <= row_base + (is_clear ? 15'(SCREEN_W) : 15'(SPRITE_W));
    end else begin
      col      <= col + 8'd1;
    end
  end

  // Stage-1 register. It lines up the issued coordinate with the ROM data that comes back one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d    <= 1'b0;
      clear_d    <= 1'b0;
      onscreen_d <= 1'b0;
      x_d        <= '0;
      y_d        <= '0;
    end else begin
      valid_d <= issuing;
      if (issuing) begin
        clear_d <= is_clear;
        if (is_clear) begin
          x_d        <= {1'b0, col};
          y_d        <= {1'b0, row};
          onscreen_d <= 1'b1;
        end else begin
          x_d        <= x_sum;
          y_d        <= y_sum;
          onscreen_d <= (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));
        end
      end
    end
  end

  assign bus.screen_addr = is_clear        ? row_base + 15'(col)       : '0;
  assign bus.sprite_addr = (state == DRAW) ? row_base[10:0] + 11'(col) : '0;

  assign q_sel          = clear_d ? bus.screen_q : bus.sprite_q;
  assign bus.vga_x      = x_d[7:0];
  assign bus.vga_y      = y_d[6:0];
  assign bus.vga_colour = valid_d ? q_sel : 3'b000;
  assign bus.plot       = valid_d && (clear_d || (bus.sprite_q != TRANSPARENT && onscreen_d));
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == FLUSH);

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Directed bench for sprite_blit_engine. Synchronous ROM models feed the
// DUT. Every expected plot is queued at launch time and popped when the
// DUT asserts plot.
module tb_sprite_blit_engine;

  typedef struct {
    int x;
    int y;
    int c;
  } px_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt  = 0;
  int   check_cnt = 0;
  int   plot_cnt  = 0;
  bit   sb_en     = 1'b0;
  int   spr_pat   = 0;
  px_t  sb[$];

  sprite_blit_if bus ();

  sprite_blit_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] scr_fn(input int a);
    return 3'((a * 5) + (a / 160));
  endfunction

  function automatic logic [2:0] spr_fn(input int a);
    case (spr_pat)
      0:       return 3'b101;
      1:       return (a % 2 == 0) ? 3'b000 : 3'((a % 7) + 1);
      default: return 3'((a % 7) + 1);
    endcase
  endfunction

  function automatic int pk(input int x, input int y, input int c);
    return (x << 16) | (y << 8) | c;
  endfunction

  // Synchronous ROM models with one cycle of read latency.
  always @(posedge clk) begin
    bus.screen_q <= scr_fn(int'(bus.screen_addr));
    bus.sprite_q <= spr_fn(int'(bus.sprite_addr));
  end

  task automatic check(input string tag, input int obs, input int exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every plot must match the next queued pixel.
  always @(negedge clk) begin
    if (sb_en && bus.plot === 1'b1) begin
      px_t e;
      plot_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_plot", pk(int'(bus.vga_x), int'(bus.vga_y), int'(bus.vga_colour)), -1);
      end else begin
        e = sb.pop_front();
        check("plot_pixel", pk(int'(bus.vga_x), int'(bus.vga_y), int'(bus.vga_colour)),
              pk(e.x, e.y, e.c));
      end
    end
  end

  task automatic push_clear();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        sb.push_back('{x, y, int'(scr_fn(y * 160 + x))});
  endtask

  task automatic push_draw(input int px, input int py);
    for (int r = 0; r < 40; r++)
      for (int c = 0; c < 40; c++) begin
        int a = r * 40 + c;
        int col = int'(spr_fn(a));
        if (col != 0 && px + c < 160 && py + r < 120)
          sb.push_back('{px + c, py + r, col});
      end
  endtask

  // Launch: the start inputs are high across exactly one rising edge (the start edge).
  task automatic launch(input logic clr, input logic drw, input logic [7:0] px, input logic [6:0] py);
    @(posedge clk);
    #1;
    bus.start_clear = clr;
    bus.start_draw  = drw;
    bus.pos_x       = px;
    bus.pos_y       = py;
    @(posedge clk);
    #1;
    bus.start_clear = 1'b0;
    bus.start_draw  = 1'b0;
  endtask

  // Follow one operation to done, then check duration, busy length, plot count and the idle state that follows.
  // act_kind 1 pulses start_draw at act_cyc; act_kind 2 asserts reset at act_cyc.
  task automatic run_op(input string tag, input int exp_dur, input int exp_plots,
                        input int act_cyc, input int act_kind);
    int cyc = 0, busy_cnt = 0, done_cnt = 0, done_at = 0, idle_busy = 0;
    while (cyc < exp_dur + 50) begin
      @(negedge clk);
      cyc++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (cyc == 1) begin
        check({tag, "_busy_rise"}, int'(bus.busy), 1);
        check({tag, "_no_early_plot"}, int'(bus.plot), 0);
      end
      if (act_kind == 1 && cyc == act_cyc)     bus.start_draw = 1'b1;
      if (act_kind == 1 && cyc == act_cyc + 1) bus.start_draw = 1'b0;
      if (act_kind == 2 && cyc == act_cyc) begin
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check({tag, "_rst_busy"}, int'(bus.busy), 0);
        check({tag, "_rst_plot"}, int'(bus.plot), 0);
        for (int i = 0; i < 10; i++) begin
          if (bus.done === 1'b1) done_cnt++;
          @(negedge clk);
        end
        check({tag, "_rst_no_done"}, done_cnt, 0);
        return;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at = cyc;
        break;
      end
    end
    check({tag, "_done_cycle"}, done_at, exp_dur);
    check({tag, "_busy_cycles"}, busy_cnt, exp_dur);
    @(negedge clk);
    check({tag, "_done_width"}, int'(bus.done), 0);
    check({tag, "_plot_count"}, plot_cnt, exp_plots);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_idle_addr"}, int'(bus.screen_addr) + int'(bus.sprite_addr), 0);
    for (int i = 0; i < 6; i++) begin
      if (bus.busy !== 1'b0 || bus.plot !== 1'b0) idle_busy++;
      @(negedge clk);
    end
    check({tag, "_stays_idle"}, idle_busy, 0);
  endtask

  initial begin
    bus.start_draw  = 1'b0;
    bus.start_clear = 1'b0;
    bus.pos_x       = '0;
    bus.pos_y       = '0;
    bus.screen_q    = '0;
    bus.sprite_q    = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_plot", int'(bus.plot), 0);
    check("rst_vga", pk(int'(bus.vga_x), int'(bus.vga_y), int'(bus.vga_colour)), 0);
    check("rst_addr", int'(bus.screen_addr) + int'(bus.sprite_addr), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    sb_en = 1'b1;

    // Full background redraw.
    plot_cnt = 0;
    push_clear();
    launch(1'b1, 1'b0, 8'd0, 7'd0);
    run_op("clear", 19201, 19200, 0, 0);

    // Opaque sprite at (10,20).
    spr_pat = 0;
    plot_cnt = 0;
    push_draw(10, 20);
    launch(1'b0, 1'b1, 8'd10, 7'd20);
    run_op("draw_solid", 1601, 1600, 0, 0);

    // Even addresses transparent.
    spr_pat = 1;
    plot_cnt = 0;
    push_draw(10, 20);
    launch(1'b0, 1'b1, 8'd10, 7'd20);
    run_op("draw_transp", 1601, 800, 0, 0);

    // Clipping at the bottom-right corner.
    spr_pat = 2;
    plot_cnt = 0;
    push_draw(140, 100);
    launch(1'b0, 1'b1, 8'd140, 7'd100);
    run_op("draw_clip", 1601, 400, 0, 0);

    // Simultaneous starts: the clear wins, and a draw pulsed while busy is ignored.
    plot_cnt = 0;
    push_clear();
    launch(1'b1, 1'b1, 8'd50, 7'd50);
    run_op("both_start", 19201, 19200, 100, 1);

    // Reset in the middle of a draw.
    sb_en = 1'b0;
    launch(1'b0, 1'b1, 8'd10, 7'd20);
    run_op("draw_reset", 1601, 0, 700, 2);
    sb_en = 1'b1;

    // Fresh full sweep after the reset.
    plot_cnt = 0;
    push_draw(0, 0);
    launch(1'b0, 1'b1, 8'd0, 7'd0);
    run_op("draw_after_rst", 1601, 1600, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
